// File: rtl/csr_excp_unit.sv
// Privileged CSR file with exception/ERTN sequencing, interrupt status and the
// constant timer. Two commit slots may write CSRs in the same cycle.
module csr_excp_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        excp_flush,
  input  logic        ertn_flush,
  input  logic [31:0] csr_era,
  input  logic [5:0]  csr_ecode,
  input  logic [8:0]  csr_esubcode,
  input  logic        va_error,
  input  logic [31:0] bad_va,
  input  logic        excp_tlbrefill,
  input  logic        excp_tlb,
  input  logic [18:0] excp_tlb_vppn,
  input  logic        csr_we_0,
  input  logic [13:0] csr_waddr_0,
  input  logic [31:0] csr_wdata_0,
  input  logic        csr_we_1,
  input  logic [13:0] csr_waddr_1,
  input  logic [31:0] csr_wdata_1,
  input  logic [13:0] csr_raddr,
  output logic [31:0] csr_rdata,
  input  logic [7:0]  hw_int,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        int_pending,
  output logic [1:0]  plv,
  output logic        da,
  output logic        pg
);

  localparam logic [13:0] ADDR_CRMD      = 14'h000;
  localparam logic [13:0] ADDR_PRMD      = 14'h001;
  localparam logic [13:0] ADDR_ECFG      = 14'h004;
  localparam logic [13:0] ADDR_ESTAT     = 14'h005;
  localparam logic [13:0] ADDR_ERA       = 14'h006;
  localparam logic [13:0] ADDR_BADV      = 14'h007;
  localparam logic [13:0] ADDR_EENTRY    = 14'h00C;
  localparam logic [13:0] ADDR_TLBEHI    = 14'h011;
  localparam logic [13:0] ADDR_SAVE0     = 14'h030;
  localparam logic [13:0] ADDR_SAVE1     = 14'h031;
  localparam logic [13:0] ADDR_SAVE2     = 14'h032;
  localparam logic [13:0] ADDR_SAVE3     = 14'h033;
  localparam logic [13:0] ADDR_TCFG      = 14'h041;
  localparam logic [13:0] ADDR_TVAL      = 14'h042;
  localparam logic [13:0] ADDR_TICLR     = 14'h044;
  localparam logic [13:0] ADDR_TLBRENTRY = 14'h088;

  logic [1:0]       r_plv;
  logic             r_ie;
  logic             r_da;
  logic             r_pg;
  logic [1:0]       r_pplv;
  logic             r_pie;
  logic [12:0]      r_lie;
  logic [1:0]       r_is_sw;
  logic [7:0]       r_is_hw;
  logic             r_is_ti;
  logic [5:0]       r_ecode;
  logic [8:0]       r_esubcode;
  logic [31:0]      r_era;
  logic [31:0]      r_badv;
  logic [25:0]      r_eentry;
  logic [18:0]      r_vppn;
  logic [3:0][31:0] r_save;
  logic [31:0]      r_tcfg;
  logic [31:0]      r_tval;
  logic [25:0]      r_tlbrentry;

  logic [1:0]       w_we;
  logic [1:0][13:0] w_waddr;
  logic [1:0][31:0] w_wdata;
  logic             w_tcfg_wr;
  logic             w_ticlr_clr;
  logic [12:0]      w_is;

  assign w_we    = {csr_we_1, csr_we_0};
  assign w_waddr = {csr_waddr_1, csr_waddr_0};
  assign w_wdata = {csr_wdata_1, csr_wdata_0};

  assign w_tcfg_wr = (csr_we_0 && csr_waddr_0 == ADDR_TCFG) ||
                     (csr_we_1 && csr_waddr_1 == ADDR_TCFG);

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
  always_comb begin
    w_ticlr_clr = 1'b0;
    if (csr_we_0 && csr_waddr_0 == ADDR_TICLR) w_ticlr_clr = csr_wdata_0[0];
    if (csr_we_1 && csr_waddr_1 == ADDR_TICLR) w_ticlr_clr = csr_wdata_1[0];
  end

  // IS[10] and IS[12] have no source in this unit and read as zero.
  assign w_is = {1'b0, r_is_ti, 1'b0, r_is_hw, r_is_sw};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_plv       <= 2'd0;
      r_ie        <= 1'b0;
      r_da        <= 1'b1;
      r_pg        <= 1'b0;
      r_pplv      <= 2'd0;
      r_pie       <= 1'b0;
      r_lie       <= '0;
      r_is_sw     <= '0;
      r_is_hw     <= '0;
      r_is_ti     <= 1'b0;
      r_ecode     <= '0;
      r_esubcode  <= '0;
      r_era       <= '0;
      r_badv      <= '0;
      r_eentry    <= '0;
      r_vppn      <= '0;
      r_save      <= '0;
      r_tcfg      <= '0;
      r_tval      <= '0;
      r_tlbrentry <= '0;
    end else begin
      // NOTE: non-blocking updates take the last assignment in program order, so slot 1
      // overrides slot 0 and the exception/ERTN updates below override software writes.
      for (int k = 0; k < 2; k++) begin
        if (w_we[k]) begin
          case (w_waddr[k])
            ADDR_CRMD:      {r_pg, r_da, r_ie, r_plv} <= w_wdata[k][4:0];
            ADDR_PRMD:      {r_pie, r_pplv} <= w_wdata[k][2:0];
            ADDR_ECFG:      r_lie <= w_wdata[k][12:0];
            ADDR_ESTAT:     r_is_sw <= w_wdata[k][1:0];
            ADDR_ERA:       r_era <= w_wdata[k];
            ADDR_BADV:      r_badv <= w_wdata[k];
            ADDR_EENTRY:    r_eentry <= w_wdata[k][31:6];
            ADDR_TLBEHI:    r_vppn <= w_wdata[k][31:13];
            ADDR_SAVE0, ADDR_SAVE1, ADDR_SAVE2, ADDR_SAVE3:
                            r_save[w_waddr[k][1:0]] <= w_wdata[k];
            ADDR_TCFG: begin
              r_tcfg <= w_wdata[k];
              r_tval <= {w_wdata[k][31:2], 2'b00};
            end
            ADDR_TLBRENTRY: r_tlbrentry <= w_wdata[k][31:6];
            default: ;
          endcase
        end
      end

      r_is_hw <= hw_int;
      if (w_ticlr_clr) r_is_ti <= 1'b0;

      // Expiry is handled after the TICLR clear so a coincident expiry leaves IS[11] set.
      if (r_tcfg[0] && !w_tcfg_wr) begin
        if (r_tval != '0) begin
          r_tval <= r_tval - 32'd1;
        end else begin
          r_is_ti <= 1'b1;
          if (r_tcfg[1]) r_tval <= {r_tcfg[31:2], 2'b00};
          else           r_tcfg[0] <= 1'b0;
        end
      end

      if (excp_flush) begin
        r_pplv     <= r_plv;
        r_pie      <= r_ie;
        r_plv      <= 2'd0;
        r_ie       <= 1'b0;
        r_ecode    <= csr_ecode;
        r_esubcode <= csr_esubcode;
        r_era      <= csr_era;
        if (va_error) r_badv <= bad_va;
        if (excp_tlb) r_vppn <= excp_tlb_vppn;
        if (excp_tlbrefill) begin
          r_da <= 1'b1;
          r_pg <= 1'b0;
        end
      end else if (ertn_flush) begin
        r_plv <= r_pplv;
        r_ie  <= r_pie;
        if (r_ecode == 6'h3F) begin
          r_da <= 1'b0;
          r_pg <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_raddr)
      ADDR_CRMD:      csr_rdata = {27'd0, r_pg, r_da, r_ie, r_plv};
      ADDR_PRMD:      csr_rdata = {29'd0, r_pie, r_pplv};
      ADDR_ECFG:      csr_rdata = {19'd0, r_lie};
      ADDR_ESTAT:     csr_rdata = {1'b0, r_esubcode, r_ecode, 3'd0, w_is};
      ADDR_ERA:       csr_rdata = r_era;
      ADDR_BADV:      csr_rdata = r_badv;
      ADDR_EENTRY:    csr_rdata = {r_eentry, 6'd0};
      ADDR_TLBEHI:    csr_rdata = {r_vppn, 13'd0};
      ADDR_SAVE0, ADDR_SAVE1, ADDR_SAVE2, ADDR_SAVE3:
                      csr_rdata = r_save[csr_raddr[1:0]];
      ADDR_TCFG:      csr_rdata = r_tcfg;
      ADDR_TVAL:      csr_rdata = r_tval;
      ADDR_TLBRENTRY: csr_rdata = {r_tlbrentry, 6'd0};
      default:        csr_rdata = '0;
    endcase
  end

  assign redirect_valid = !rst && (excp_flush || ertn_flush);

  always_comb begin
    redirect_pc = '0;
    if (redirect_valid) begin
      if (excp_flush && excp_tlbrefill) redirect_pc = {r_tlbrentry, 6'd0};
      else if (excp_flush)              redirect_pc = {r_eentry, 6'd0};
      else                              redirect_pc = r_era;
    end
  end

  assign int_pending = r_ie && |(w_is & r_lie);
  assign plv = r_plv;
  assign da  = r_da;
  assign pg  = r_pg;

endmodule

// File: tb/tb_csr_excp_unit.sv
// Directed scenarios for csr_excp_unit followed by randomized traffic checked
// against a word-image CSR model built from the architectural rules.
module tb_csr_excp_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        excp_flush, ertn_flush;
  logic [31:0] csr_era;
  logic [5:0]  csr_ecode;
  logic [8:0]  csr_esubcode;
  logic        va_error;
  logic [31:0] bad_va;
  logic        excp_tlbrefill, excp_tlb;
  logic [18:0] excp_tlb_vppn;
  logic        csr_we_0, csr_we_1;
  logic [13:0] csr_waddr_0, csr_waddr_1;
  logic [31:0] csr_wdata_0, csr_wdata_1;
  logic [13:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic [7:0]  hw_int;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        int_pending;
  logic [1:0]  plv;
  logic        da, pg;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  csr_excp_unit dut (
    .clk(clk), .rst(rst),
    .excp_flush(excp_flush), .ertn_flush(ertn_flush),
    .csr_era(csr_era), .csr_ecode(csr_ecode), .csr_esubcode(csr_esubcode),
    .va_error(va_error), .bad_va(bad_va),
    .excp_tlbrefill(excp_tlbrefill), .excp_tlb(excp_tlb), .excp_tlb_vppn(excp_tlb_vppn),
    .csr_we_0(csr_we_0), .csr_waddr_0(csr_waddr_0), .csr_wdata_0(csr_wdata_0),
    .csr_we_1(csr_we_1), .csr_waddr_1(csr_waddr_1), .csr_wdata_1(csr_wdata_1),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .hw_int(hw_int),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .int_pending(int_pending), .plv(plv), .da(da), .pg(pg)
  );

  // ---------------- reference model: one 32-bit image per CSR address ----------------
  logic [31:0] m [256];
  logic [31:0] n [256];

  function automatic logic [31:0] sw_mask(input logic [13:0] a);
    case (a)
      14'h000: return 32'h0000_001F;
      14'h001: return 32'h0000_0007;
      14'h004: return 32'h0000_1FFF;
      14'h005: return 32'h0000_0003;
      14'h006, 14'h007, 14'h030, 14'h031, 14'h032, 14'h033, 14'h041: return 32'hFFFF_FFFF;
      14'h00C, 14'h088: return 32'hFFFF_FFC0;
      14'h011: return 32'hFFFF_E000;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_rd(input logic [13:0] a);
    if (sw_mask(a) != 0 || a == 14'h042) return m[a[7:0]];
    return 32'h0;
  endfunction

  function automatic logic m_rv();
    return !rst && (excp_flush || ertn_flush);
  endfunction

  function automatic logic [31:0] m_pc();
    if (!m_rv()) return 32'h0;
    if (excp_flush && excp_tlbrefill) return m[8'h88];
    if (excp_flush) return m[8'h0C];
    return m[8'h06];
  endfunction

  function automatic logic m_int();
    return m[0][2] && ((m[5][12:0] & m[4][12:0]) != 13'd0);
  endfunction

  always @(posedge clk) begin
    logic        tcfg_wr, ticlr, expire, we;
    logic [13:0] a;
    logic [31:0] d, mk;
    if (rst) begin
      for (int i = 0; i < 256; i++) m[i] = 32'h0;
      m[0] = 32'h8;
    end else begin
      n = m;
      tcfg_wr = 1'b0; ticlr = 1'b0; expire = 1'b0;
      for (int k = 0; k < 2; k++) begin
        we = (k == 0) ? csr_we_0 : csr_we_1;
        a  = (k == 0) ? csr_waddr_0 : csr_waddr_1;
        d  = (k == 0) ? csr_wdata_0 : csr_wdata_1;
        if (we) begin
          mk = sw_mask(a);
          if (mk != 0) n[a[7:0]] = (n[a[7:0]] & ~mk) | (d & mk);
          if (a == 14'h041) begin tcfg_wr = 1'b1; n[8'h42] = d & ~32'h3; end
          if (a == 14'h044) ticlr = d[0];
        end
      end
      n[5][9:2] = hw_int;
      if (m[8'h41][0] && !tcfg_wr) begin
        if (m[8'h42] != 0) n[8'h42] = m[8'h42] - 1;
        else begin
          expire = 1'b1;
          if (m[8'h41][1]) n[8'h42] = m[8'h41] & ~32'h3;
          else             n[8'h41][0] = 1'b0;
        end
      end
      if (ticlr)  n[5][11] = 1'b0;
      if (expire) n[5][11] = 1'b1;
      if (excp_flush) begin
        n[1] = {29'd0, m[0][2:0]};
        n[0][2:0] = 3'd0;
        n[5][30:16] = {csr_esubcode, csr_ecode};
        n[6] = csr_era;
        if (va_error) n[7] = bad_va;
        if (excp_tlb) n[8'h11] = {excp_tlb_vppn, 13'd0};
        if (excp_tlbrefill) n[0][4:3] = 2'b01;
      end else if (ertn_flush) begin
        n[0][2:0] = m[1][2:0];
        if (m[5][21:16] == 6'h3F) n[0][4:3] = 2'b10;
      end
      m = n;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [13:0] a, input logic [31:0] exp);
    csr_raddr = a;
    #2;
    check(tag, csr_rdata, exp);
  endtask

  task automatic model_chk(input int i);
    check($sformatf("r%0d_rv", i), {31'd0, redirect_valid}, {31'd0, m_rv()});
    check($sformatf("r%0d_pc", i), redirect_pc, m_pc());
    check($sformatf("r%0d_int", i), {31'd0, int_pending}, {31'd0, m_int()});
    check($sformatf("r%0d_mode", i), {28'd0, pg, da, plv}, {28'd0, m[0][4:3], m[0][1:0]});
    check($sformatf("r%0d_rdata_%0h", i, csr_raddr), csr_rdata, m_rd(csr_raddr));
  endtask

  task automatic clear_inputs();
    excp_flush = 0; ertn_flush = 0; csr_era = 0; csr_ecode = 0; csr_esubcode = 0;
    va_error = 0; bad_va = 0; excp_tlbrefill = 0; excp_tlb = 0; excp_tlb_vppn = 0;
    csr_we_0 = 0; csr_we_1 = 0; csr_waddr_0 = 0; csr_waddr_1 = 0;
    csr_wdata_0 = 0; csr_wdata_1 = 0; hw_int = 0;
  endtask

  logic [13:0] addr_list [18] = '{14'h000, 14'h001, 14'h004, 14'h005, 14'h006, 14'h007,
                                  14'h00C, 14'h011, 14'h030, 14'h031, 14'h032, 14'h033,
                                  14'h041, 14'h042, 14'h044, 14'h088, 14'h002, 14'h100};

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; csr_raddr = 0;
    clear_inputs();
    tick(); tick();

    // Reset: flushes and writes are ignored, redirect stays low
    excp_flush = 1; ertn_flush = 1;
    #2 check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    tick();
    excp_flush = 0; ertn_flush = 0;
    csr_we_0 = 1; csr_waddr_0 = 14'h041; csr_wdata_0 = 32'hB;
    tick();
    csr_we_0 = 0; rst = 0;
    rd_chk("rst_crmd", 14'h000, 32'h8);
    rd_chk("rst_tcfg", 14'h041, 32'h0);
    rd_chk("rst_tval", 14'h042, 32'h0);
    check("rst_mode", {28'd0, pg, da, plv}, 32'h4);
    tick();

    // hw_int reaches ESTAT.IS[9:2] one edge later
    hw_int = 8'hA5;
    rd_chk("hwint_before", 14'h005, 32'h0);
    tick();
    hw_int = 8'h00;
    rd_chk("hwint_after", 14'h005, 32'h294);
    tick();

    // Plain exception from PLV3 with IE set
    csr_we_0 = 1; csr_waddr_0 = 14'h000; csr_wdata_0 = 32'h7;
    csr_we_1 = 1; csr_waddr_1 = 14'h00C; csr_wdata_1 = 32'h1C008000;
    tick();
    csr_we_0 = 0; csr_we_1 = 0;
    excp_flush = 1; csr_ecode = 6'hB; csr_era = 32'h1C000100;
    #2;
    check("excp_rv", {31'd0, redirect_valid}, 32'd1);
    check("excp_pc", redirect_pc, 32'h1C008000);
    tick();
    excp_flush = 0;
    rd_chk("excp_crmd", 14'h000, 32'h0);
    rd_chk("excp_prmd", 14'h001, 32'h7);
    rd_chk("excp_era", 14'h006, 32'h1C000100);
    tick();
    rd_chk("excp_estat", 14'h005, 32'h000B0000);
    tick();

    // TLB refill exception, then ERTN back
    csr_we_0 = 1; csr_waddr_0 = 14'h088; csr_wdata_0 = 32'h00008000;
    tick();
    csr_we_0 = 0;
    excp_flush = 1; excp_tlbrefill = 1; excp_tlb = 1; excp_tlb_vppn = 19'h2A5A5;
    csr_ecode = 6'h3F; va_error = 1; bad_va = 32'h00402000; csr_era = 32'h1C000200;
    #2 check("refill_pc", redirect_pc, 32'h00008000);
    tick();
    excp_flush = 0; excp_tlbrefill = 0; excp_tlb = 0; va_error = 0;
    rd_chk("refill_badv", 14'h007, 32'h00402000);
    rd_chk("refill_tlbehi", 14'h011, {19'h2A5A5, 13'd0});
    rd_chk("refill_crmd", 14'h000, 32'h8);
    tick();
    ertn_flush = 1;
    #2 check("ertn_pc", redirect_pc, 32'h1C000200);
    tick();
    ertn_flush = 0;
    rd_chk("ertn_crmd", 14'h000, 32'h10);
    check("ertn_da_pg", {30'd0, pg, da}, 32'h2);
    tick();

    // Exception and ERTN together: exception path only
    excp_flush = 1; ertn_flush = 1; csr_ecode = 6'h1; csr_era = 32'h1C000300;
    #2 check("both_pc", redirect_pc, 32'h1C008000);
    tick();
    excp_flush = 0; ertn_flush = 0;
    rd_chk("both_era", 14'h006, 32'h1C000300);
    rd_chk("both_estat", 14'h005, 32'h00010000);
    tick();

    // Same-address dual write and ESTAT write mask
    csr_we_0 = 1; csr_waddr_0 = 14'h030; csr_wdata_0 = 32'h11111111;
    csr_we_1 = 1; csr_waddr_1 = 14'h030; csr_wdata_1 = 32'h22222222;
    tick();
    csr_we_1 = 0;
    csr_waddr_0 = 14'h005; csr_wdata_0 = 32'hFFFFFFFF;
    rd_chk("save0_slot1", 14'h030, 32'h22222222);
    tick();
    csr_we_0 = 0;
    rd_chk("estat_mask", 14'h005, 32'h00010003);
    tick();

    // Periodic timer: InitVal=2 -> TVAL 8, expiry, reload, interrupt, TICLR
    csr_we_0 = 1; csr_waddr_0 = 14'h004; csr_wdata_0 = 32'h800;
    csr_we_1 = 1; csr_waddr_1 = 14'h000; csr_wdata_1 = 32'h14;
    tick();
    csr_we_1 = 0;
    csr_waddr_0 = 14'h041; csr_wdata_0 = 32'h0000000B;
    tick();
    csr_we_0 = 0;
    rd_chk("tval_load", 14'h042, 32'h8);
    rd_chk("tcfg_val", 14'h041, 32'hB);
    for (int i = 0; i < 8; i++) tick();
    rd_chk("tval_zero", 14'h042, 32'h0);
    check("int_before", {31'd0, int_pending}, 32'd0);
    tick();
    rd_chk("tval_reload", 14'h042, 32'h8);
    rd_chk("estat_ti", 14'h005, 32'h00010803);
    check("int_timer", {31'd0, int_pending}, 32'd1);
    csr_we_0 = 1; csr_waddr_0 = 14'h044; csr_wdata_0 = 32'h1;
    tick();
    csr_we_0 = 0;
    rd_chk("ticlr_estat", 14'h005, 32'h00010003);
    rd_chk("ticlr_rd", 14'h044, 32'h0);
    check("ticlr_int", {31'd0, int_pending}, 32'd0);
    tick();

    // Reset mid-count
    tick();
    rd_chk("tval_five", 14'h042, 32'h5);
    rst = 1; excp_flush = 1;
    #2 check("midrst_rv", {31'd0, redirect_valid}, 32'd0);
    tick();
    rd_chk("midrst_tval", 14'h042, 32'h0);
    rd_chk("midrst_crmd", 14'h000, 32'h8);
    check("midrst_rv2", {31'd0, redirect_valid}, 32'd0);
    tick();
    excp_flush = 0; rst = 0;
    tick();
    rd_chk("postrst_tval", 14'h042, 32'h0);
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      excp_flush = ($urandom_range(0, 7) == 0);
      ertn_flush = ($urandom_range(0, 7) == 0);
      csr_era = $urandom;
      csr_ecode = ($urandom_range(0, 2) == 0) ? 6'h3F : 6'($urandom);
      csr_esubcode = 9'($urandom);
      va_error = 1'($urandom);
      bad_va = $urandom;
      excp_tlbrefill = ($urandom_range(0, 3) == 0);
      excp_tlb = 1'($urandom);
      excp_tlb_vppn = 19'($urandom);
      csr_we_0 = ($urandom_range(0, 2) != 0);
      csr_waddr_0 = addr_list[$urandom_range(0, 17)];
      csr_wdata_0 = (csr_waddr_0 == 14'h041) ? 32'($urandom_range(0, 31)) : $urandom;
      csr_we_1 = ($urandom_range(0, 2) != 0);
      csr_waddr_1 = ($urandom_range(0, 3) == 0) ? csr_waddr_0 : addr_list[$urandom_range(0, 17)];
      csr_wdata_1 = (csr_waddr_1 == 14'h041) ? 32'($urandom_range(0, 31)) : $urandom;
      hw_int = 8'($urandom);
      csr_raddr = addr_list[$urandom_range(0, 17)];
      #2;
      model_chk(i);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/csr_excp_unit.md
CSR_EXCP_UNIT -- requirements
Module: csr_excp_unit

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have: excp_flush in 1 exception commit; ertn_flush in 1 ertn commit; csr_era in 32 faulting pc; csr_ecode in 6; csr_esubcode in 9.
REQ-003 SHALL have: va_error in 1 BADV valid; bad_va in 32; excp_tlbrefill in 1; excp_tlb in 1; excp_tlb_vppn in 19.
REQ-004 SHALL have two commit-slot CSR write ports k=0,1: csr_we_k in 1; csr_waddr_k in 14; csr_wdata_k in 32.
REQ-005 SHALL have: csr_raddr in 14; csr_rdata out 32, combinational; hw_int in 8 hardware interrupt lines.
REQ-006 SHALL have: redirect_valid out 1; redirect_pc out 32; int_pending out 1; plv out 2 (CRMD.PLV); da out 1; pg out 1.

Function
REQ-007 SHALL implement CSRs at these addresses: CRMD 0x0 {PG[4],DA[3],IE[2],PLV[1:0]}, PRMD 0x1 {PIE[2],PPLV[1:0]}, ECFG 0x4 {LIE[12:0]}, ESTAT 0x5 {EsubCode[30:22],Ecode[21:16],IS[12:0]}, ERA 0x6, BADV 0x7, EENTRY 0xC {VA[31:6]}, TLBEHI 0x11 {VPPN[31:13]}, SAVE0-3 0x30-0x33, TCFG 0x41 {InitVal[31:2],Periodic[1],En[0]}, TVAL 0x42, TICLR 0x44, TLBRENTRY 0x88 {PA[31:6]}.
REQ-008 SHALL hold unimplemented field bits at 0; writes to them ignored.
REQ-009 SHALL treat ESTAT.IS[12:2] and TVAL as read-only to software; only ESTAT.IS[1:0] writable.
REQ-010 SHALL return 0 for unmapped addresses and for TICLR reads.
REQ-011 SHALL apply writes at the next clk edge; when both slots write the same address, slot 1 wins.
REQ-012 SHALL, on excp_flush, at the next edge: PRMD.PPLV<=CRMD.PLV, PRMD.PIE<=CRMD.IE, CRMD.PLV<=0, CRMD.IE<=0, ESTAT.Ecode<=csr_ecode, ESTAT.EsubCode<=csr_esubcode, ERA<=csr_era.
REQ-013 SHALL, on excp_flush: BADV<=bad_va only if va_error; TLBEHI.VPPN<=excp_tlb_vppn only if excp_tlb; CRMD.DA<=1 and CRMD.PG<=0 only if excp_tlbrefill.
REQ-014 SHALL, on ertn_flush without excp_flush, at the next edge: CRMD.PLV<=PRMD.PPLV, CRMD.IE<=PRMD.PIE; if ESTAT.Ecode==0x3F also CRMD.DA<=0, CRMD.PG<=1.
REQ-015 SHALL give excp_flush priority over ertn_flush in the same cycle.
REQ-016 SHALL give excp/ertn field updates priority over same-cycle software writes to those fields; other fields still take the write.
REQ-017 SHALL drive redirect_valid = excp_flush | ertn_flush combinationally in the same cycle.
REQ-018 SHALL drive redirect_pc: excp_flush&excp_tlbrefill -> TLBRENTRY; excp_flush -> EENTRY; ertn_flush -> ERA (pre-update register values); otherwise 0.
REQ-019 SHALL register hw_int into ESTAT.IS[9:2] every cycle (one-cycle latency).
REQ-020 SHALL, on a TCFG write, load TVAL<={wdata[31:2],2'b00} at the same edge.
REQ-021 SHALL, while TCFG.En=1 and no TCFG write: if TVAL!=0, decrement TVAL by 1; if TVAL==0, set ESTAT.IS[11] and either reload TVAL<={InitVal,2'b00} (Periodic=1) or clear TCFG.En (Periodic=0).
REQ-022 SHALL, on a TICLR write with wdata[0]=1, clear ESTAT.IS[11]; a same-cycle timer expiry wins and IS[11] ends at 1.
REQ-023 SHALL drive int_pending = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]), combinational from registered state.

Reset
REQ-024 SHALL, on rst, set CRMD=0x00000008 (DA=1, PG=0, IE=0, PLV=0) and all other CSRs, TVAL and ESTAT.IS to 0.
REQ-025 SHALL, with rst asserted, force redirect_valid=0 and ignore excp_flush, ertn_flush, writes and the timer.

Verification
REQ-026 SHALL cover: CRMD=0x7 (PLV=3, IE=1), EENTRY=0x1C008000, excp_flush, ecode=0xB, csr_era=0x1C000100 -> same cycle redirect_pc=0x1C008000; next cycle CRMD.PLV=0, IE=0, PRMD=0x7, ERA=0x1C000100, ESTAT.Ecode=0xB.
REQ-027 SHALL cover: TLB refill, excp_tlbrefill=1, ecode=0x3F, bad_va=0x00402000, va_error=1, TLBRENTRY=0x00008000 -> redirect_pc=0x00008000; BADV=0x00402000; DA=1, PG=0; then ertn_flush -> redirect_pc=ERA, DA=0, PG=1.
REQ-028 SHALL cover: TCFG write 0x0000000B (InitVal=2, Periodic=1, En=1) -> TVAL=8, counts to 0, IS[11]=1 on the following edge, TVAL reloads 8; with ECFG.LIE[11]=1 and IE=1, int_pending=1; TICLR write 1 -> IS[11]=0.
REQ-029 SHALL cover: excp_flush and ertn_flush asserted together -> exception path only, redirect_pc=EENTRY.
REQ-030 SHALL cover: both slots write SAVE0 (0x11111111, 0x22222222) -> SAVE0 reads 0x22222222; write to 0x5 with 0xFFFFFFFF -> only IS[1:0] change.
REQ-031 SHALL cover: rst asserted mid-count with TVAL=5 -> TVAL=0, CRMD=0x8, redirect_valid=0.
